mac_feeder: RTL and testbench

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mm_pkg.sv | 22 ++
 rtl/mac_feeder_addr_gen.sv | 83 ++++++++
 rtl/mac_feeder.sv | 151 +++++++++++++++
 tb/tb_mac_feeder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply feeder: default dimensions,
// operand width, FSM encoding and a configuration range check.
package mm_pkg;

  localparam int unsigned DIM_MAX = 8;
  localparam int unsigned DIM_W   = 4;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } feeder_state_e;

  // A dimension is usable when it is non-zero and fits the array.
  function automatic logic dim_ok(int unsigned dim, int unsigned lim);
    return (dim != 0) && (dim <= lim);
  endfunction

endpackage

// File: rtl/mac_feeder_addr_gen.sv
// i/j/k loop counters (k innermost) and operand address generation for a
// row-major A(M x K) * B(K x N) walk.
module mac_feeder_addr_gen #(
  parameter int unsigned DIM_W  = mm_pkg::DIM_W,
  parameter int unsigned ADDR_W = mm_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              load,
  input  logic [DIM_W-1:0]  load_m,
  input  logic [DIM_W-1:0]  load_n,
  input  logic [DIM_W-1:0]  load_k,
  input  logic              advance,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic              first_k,
  output logic              last_k,
  output logic              last_pair,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr
);

  logic [DIM_W-1:0] m_q, n_q, kl_q;
  logic [DIM_W-1:0] i_q, j_q, k_q;
  logic [DIM_W-1:0] i_d, j_d, k_d;
  logic             last_i, last_j;

  assign last_i    = (i_q == m_q - DIM_W'(1));
  assign last_j    = (j_q == n_q - DIM_W'(1));
  assign last_k    = (k_q == kl_q - DIM_W'(1));
  assign first_k   = (k_q == '0);
  assign last_pair = last_i && last_j && last_k;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (load) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (advance) begin
      if (!last_k) begin
        k_d = k_q + DIM_W'(1);
      end else begin
        k_d = '0;
        if (!last_j) begin
          j_d = j_q + DIM_W'(1);
        end else begin
          j_d = '0;
          i_d = last_i ? '0 : i_q + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_q  <= '0;
      n_q  <= '0;
      kl_q <= '0;
      i_q  <= '0;
      j_q  <= '0;
      k_q  <= '0;
    end else begin
      if (load) begin
        m_q  <= load_m;
        n_q  <= load_n;
        kl_q <= load_k;
      end
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  // Products never exceed DIM_MAX*DIM_MAX, which the address width covers.
  assign a_addr = ADDR_W'(i_q) * ADDR_W'(kl_q) + ADDR_W'(k_q);
  assign b_addr = ADDR_W'(k_q) * ADDR_W'(n_q) + ADDR_W'(j_q);
  assign row    = i_q;
  assign col    = j_q;

endmodule

// File: rtl/mac_feeder.sv
// Operand feeder for a single MAC: sequences A/B reads, aligns memory data
// with clear/valid markers and reports status. FEEDER_PERF_CNT_EN adds a
// run-cycle counter on perf_cycles_o.
module mac_feeder #(
  parameter int unsigned DIM_MAX   = mm_pkg::DIM_MAX,
  parameter int unsigned DIM_W     = mm_pkg::DIM_W,
  parameter int unsigned ADDR_W    = mm_pkg::ADDR_W,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic [DIM_W-1:0]          cfg_m_i,
  input  logic [DIM_W-1:0]          cfg_n_i,
  input  logic [DIM_W-1:0]          cfg_k_i,
  input  logic                      hold_i,
  output logic [ADDR_W-1:0]         a_addr_o,
  output logic [ADDR_W-1:0]         b_addr_o,
  output logic                      a_rd_o,
  output logic                      b_rd_o,
  input  logic [mm_pkg::DATA_W-1:0] a_rdata_i,
  input  logic [mm_pkg::DATA_W-1:0] b_rdata_i,
  output logic                      dsp_enable_o,
  output logic                      clear_o,
  output logic                      dsp_valid_o,
  output logic [mm_pkg::DATA_W-1:0] dsp_input_o,
  output logic [mm_pkg::DATA_W-1:0] dsp_weight_o,
  output logic [DIM_W-1:0]          out_row_o,
  output logic [DIM_W-1:0]          out_col_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [15:0]               perf_cycles_o
);

  import mm_pkg::*;

  localparam int unsigned DrW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  feeder_state_e    state_q, state_d;
  logic [DrW-1:0]   drain_q, drain_d;
  logic             cfg_ok, start_ok, issue;
  logic             err_q;
  logic             en_q, clr_q, vld_q;
  logic [DIM_W-1:0] row_q, col_q;
  logic [DIM_W-1:0] row, col;
  logic             first_k, last_k, last_pair;
  logic [ADDR_W-1:0] a_addr, b_addr;

  assign cfg_ok   = dim_ok(32'(cfg_m_i), DIM_MAX) && dim_ok(32'(cfg_n_i), DIM_MAX) &&
                    dim_ok(32'(cfg_k_i), DIM_MAX);
  assign start_ok = (state_q == StIdle) && start_i && cfg_ok;
  assign issue    = (state_q == StRun) && !hold_i;

  mac_feeder_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .load      (start_ok),
    .load_m    (cfg_m_i),
    .load_n    (cfg_n_i),
    .load_k    (cfg_k_i),
    .advance   (issue),
    .row       (row),
    .col       (col),
    .first_k   (first_k),
    .last_k    (last_k),
    .last_pair (last_pair),
    .a_addr    (a_addr),
    .b_addr    (b_addr)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun: begin
        if (issue && last_pair) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        if (drain_q == DrW'(DRAIN_CYC - 1)) state_d = StDone;
        else                                drain_d = drain_q + DrW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      drain_q <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      vld_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      err_q   <= (state_q == StIdle) && start_i && !cfg_ok;
      // Markers line up with the one-cycle memory read latency.
      en_q    <= issue;
      clr_q   <= issue && first_k;
      vld_q   <= issue && last_k;
      row_q   <= (issue && last_k) ? row : '0;
      col_q   <= (issue && last_k) ? col : '0;
    end
  end

  assign a_rd_o       = issue;
  assign b_rd_o       = issue;
  assign a_addr_o     = issue ? a_addr : '0;
  assign b_addr_o     = issue ? b_addr : '0;
  assign dsp_enable_o = en_q;
  assign clear_o      = clr_q;
  assign dsp_valid_o  = vld_q;
  assign dsp_input_o  = en_q ? a_rdata_i : '0;
  assign dsp_weight_o = en_q ? b_rdata_i : '0;
  assign out_row_o    = row_q;
  assign out_col_o    = col_q;
  assign busy_o       = (state_q == StRun) || (state_q == StDrain);
  assign done_o       = (state_q == StDone) || err_q;
  assign err_o        = err_q;

`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if (busy_o && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: random matrices are pushed through a
// bench-side MAC and compared with a direct matrix-product model.
module tb_mac_feeder;

  localparam int unsigned DIM_MAX = 8;
  localparam int unsigned DIM_W   = 4;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DRAIN   = 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic              hold = 1'b0;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              a_rd, b_rd;
  logic [7:0]        a_rdata = '0, b_rdata = '0;
  logic              dsp_enable, clear, dsp_valid;
  logic [7:0]        dsp_input, dsp_weight;
  logic [DIM_W-1:0]  out_row, out_col;
  logic              busy, done, err;
  logic [15:0]       perf;

  always #5 clk = ~clk;

  mac_feeder #(
    .DIM_MAX   (DIM_MAX),
    .DIM_W     (DIM_W),
    .ADDR_W    (ADDR_W),
    .DRAIN_CYC (DRAIN)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .start_i       (start),
    .cfg_m_i       (cfg_m),
    .cfg_n_i       (cfg_n),
    .cfg_k_i       (cfg_k),
    .hold_i        (hold),
    .a_addr_o      (a_addr),
    .b_addr_o      (b_addr),
    .a_rd_o        (a_rd),
    .b_rd_o        (b_rd),
    .a_rdata_i     (a_rdata),
    .b_rdata_i     (b_rdata),
    .dsp_enable_o  (dsp_enable),
    .clear_o       (clear),
    .dsp_valid_o   (dsp_valid),
    .dsp_input_o   (dsp_input),
    .dsp_weight_o  (dsp_weight),
    .out_row_o     (out_row),
    .out_col_o     (out_col),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .perf_cycles_o (perf)
  );

  logic signed [7:0] amem [64];
  logic signed [7:0] bmem [64];

  always @(posedge clk) begin
    if (a_rd) a_rdata <= amem[a_addr];
    if (b_rd) b_rdata <= bmem[b_addr];
  end

  // Bench-side MAC and event counters, sampled mid-cycle.
  typedef struct {int row; int col; int val;} res_t;
  res_t res_q[$];
  int cyc = 0, acc = 0;
  int n_issue = 0, n_en = 0, n_clr = 0, n_vld = 0, n_coinc = 0;
  int n_busy = 0, n_busy_off = 0, n_done = 0, n_err = 0, n_bad = 0;
  int start_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    int p, nxt;
    cyc <= cyc + 1;
    if (dsp_enable) begin
      p   = $signed(dsp_input) * $signed(dsp_weight);
      nxt = clear ? p : acc + p;
      acc  <= nxt;
      n_en <= n_en + 1;
      if (dsp_valid) res_q.push_back('{int'(out_row), int'(out_col), nxt});
    end
    if ((dsp_valid || clear) && !dsp_enable) n_bad <= n_bad + 1;
    if ((a_rd != b_rd) || (a_rd && !busy)) n_bad <= n_bad + 1;
    if (clear) n_clr <= n_clr + 1;
    if (dsp_valid) n_vld <= n_vld + 1;
    if (clear && dsp_valid) n_coinc <= n_coinc + 1;
    if (a_rd) n_issue <= n_issue + 1;
    if (busy) begin
      n_busy <= n_busy + 1;
      if (!dsp_enable) n_busy_off <= n_busy_off + 1;
    end
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (err) n_err <= n_err + 1;
    if (start && !busy) start_cyc <= cyc;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_rand();
    for (int x = 0; x < 64; x++) begin
      amem[x] = 8'($urandom);
      bmem[x] = 8'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply and checks every result against C = A*B.
  task automatic run_matrix(input int m, input int n, input int k, input int hold_at,
                            input int hold_len, input bit poke, input string tag);
    int cexp[$];
    int rb, ib, eb, cb, vb, qb, bb, ob, db, xb, nb;
    int t, held, tot, s;
    bit poked;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += int'(amem[i*k+kk]) * int'(bmem[kk*n+j]);
        cexp.push_back(s);
      end
    tot = m * n * k;
    rb = res_q.size(); ib = n_issue; eb = n_en; cb = n_clr; vb = n_vld; qb = n_coinc;
    bb = n_busy; ob = n_busy_off; db = n_done; xb = n_err; nb = n_bad;
    cfg_m = DIM_W'(m); cfg_n = DIM_W'(n); cfg_k = DIM_W'(k);
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0; held = 0; poked = 1'b0;
    while (n_done == db && t < 3000) begin
      if (poke && !poked && (n_issue - ib) >= 2) begin
        start = 1'b1; cfg_m = 1; cfg_n = 1; cfg_k = 1; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (held < hold_len && (n_issue - ib) >= hold_at) begin
        hold = 1'b1;
        held++;
      end else begin
        hold = 1'b0;
      end
      step();
      t++;
    end
    hold = 1'b0;
    start = 1'b0;
    check({tag, " completes"}, t < 3000, 1);
    check({tag, " issues"}, n_issue - ib, tot);
    check({tag, " enables"}, n_en - eb, tot);
    check({tag, " clears"}, n_clr - cb, m * n);
    check({tag, " valids"}, n_vld - vb, m * n);
    if (k == 1) check({tag, " clear/valid coincide"}, n_coinc - qb, m * n);
    check({tag, " done latency"}, done_cyc - start_cyc, tot + hold_len + DRAIN + 1);
    check({tag, " busy cycles"}, n_busy - bb, tot + hold_len + DRAIN);
    check({tag, " busy idle-mac cycles"}, n_busy_off - ob, hold_len + DRAIN);
    check({tag, " no err"}, n_err - xb, 0);
    check({tag, " protocol"}, n_bad - nb, 0);
    check({tag, " result count"}, res_q.size() - rb, m * n);
    if (res_q.size() - rb == m * n) begin
      for (int r = 0; r < m * n; r++) begin
        check({tag, " row"}, res_q[rb+r].row, r / n);
        check({tag, " col"}, res_q[rb+r].col, r % n);
        check({tag, " value"}, res_q[rb+r].val, cexp[r]);
      end
    end
`ifdef FEEDER_PERF_CNT_EN
    check({tag, " perf"}, perf, tot + hold_len + DRAIN);
`endif
    step();
    check({tag, " idle after done"}, {busy, done, err}, 0);
  endtask

  initial begin
    int ib, db, t;
    logic [59:0] outs;

    // Reset state
    #12;
    outs = {a_addr, b_addr, a_rd, b_rd, dsp_enable, clear, dsp_valid, dsp_input,
            dsp_weight, out_row, out_col, busy, done, err, perf};
    check("reset outputs zero", outs, 0);
    rstn = 1'b1;
    step();

    // Worked 2x2 example
    amem[0] = 1; amem[1] = 2; amem[2] = 3; amem[3] = 4;
    bmem[0] = 5; bmem[1] = 6; bmem[2] = 7; bmem[3] = 8;
    run_matrix(2, 2, 2, 0, 0, 1'b0, "2x2");
    if (res_q.size() >= 4) begin
      check("2x2 c00", res_q[0].val, 19);
      check("2x2 c01", res_q[1].val, 22);
      check("2x2 c10", res_q[2].val, 43);
      check("2x2 c11", res_q[3].val, 50);
    end

    fill_rand();
    run_matrix(3, 3, 1, 0, 0, 1'b0, "k1");

    fill_rand();
    run_matrix(2, 2, 2, 3, 3, 1'b0, "hold");

    for (int r = 0; r < 4; r++) begin
      fill_rand();
      run_matrix(int'($urandom_range(1, DIM_MAX)), int'($urandom_range(1, DIM_MAX)),
                 int'($urandom_range(1, DIM_MAX)), 0, 0, 1'b0, "rand");
    end

    fill_rand();
    run_matrix(8, 8, 8, 100, 2, 1'b0, "max");

    fill_rand();
    run_matrix(3, 2, 4, 0, 0, 1'b1, "restart ignored");

    // Illegal configurations
    ib = n_issue;
    cfg_m = 2; cfg_n = 2; cfg_k = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("k0 done", done, 1);
    check("k0 err", err, 1);
    check("k0 busy", busy, 0);
    step();
    check("k0 pulse ends", {done, err}, 0);
    repeat (4) step();
    check("k0 no reads", n_issue - ib, 0);

    cfg_m = 9; cfg_n = 1; cfg_k = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("m9 done+err", {done, err, busy}, 3'b110);
    repeat (3) step();
    check("m9 no reads", n_issue - ib, 0);

    // Reset in the middle of a run
    fill_rand();
    ib = n_issue;
    db = n_done;
    cfg_m = 3; cfg_n = 3; cfg_k = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    while ((n_issue - ib) < 5 && t < 100) begin
      step();
      t++;
    end
    check("abort reached mid-run", t < 100, 1);
    #2 rstn = 1'b0;
    #1;
    outs = {a_addr, b_addr, a_rd, b_rd, dsp_enable, clear, dsp_valid, dsp_input,
            dsp_weight, out_row, out_col, busy, done, err, perf};
    check("mid-run reset outputs zero", outs, 0);
    step();
    rstn = 1'b1;
    repeat (40) step();
    check("aborted run no done", n_done - db, 0);

    fill_rand();
    run_matrix(3, 3, 3, 0, 0, 1'b0, "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
